// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 Sobel window generator with two line buffers and a ready/valid handshake
module sobel_window_gen #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int BITS_FOR_INDEX = 10,
  parameter int sizeOfWidth    = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [sizeOfWidth-1:0]    in_pixel,
  input  logic                      in_valid,
  input  logic                      in_sof,
  output logic                      in_ready,
  output logic [3*sizeOfWidth-1:0]  temp1,
  output logic [3*sizeOfWidth-1:0]  temp2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BITS_FOR_INDEX-1:0] out_row,
  output logic [BITS_FOR_INDEX-1:0] out_col,
  output logic                      out_eof
);

  localparam int COL_AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BITS_FOR_INDEX-1:0] LAST_COL = BITS_FOR_INDEX'(WIDTH - 1);
  localparam logic [BITS_FOR_INDEX-1:0] LAST_ROW = BITS_FOR_INDEX'(HEIGHT - 1);
  localparam logic [BITS_FOR_INDEX-1:0] MIN_POS  = BITS_FOR_INDEX'(2);

  // lineOld holds row r-2, lineNew holds row r-1; neither is reset
  logic [sizeOfWidth-1:0] lineOld [WIDTH];
  logic [sizeOfWidth-1:0] lineNew [WIDTH];

  logic [BITS_FOR_INDEX-1:0] rowCnt;
  logic [BITS_FOR_INDEX-1:0] colCnt;
  logic [3*sizeOfWidth-1:0]  colPrev1;   // column c-1 of the current row
  logic [3*sizeOfWidth-1:0]  colPrev2;   // column c-2 of the current row

  logic                      accept;
  logic                      startFrame;
  logic [BITS_FOR_INDEX-1:0] curRow;
  logic [BITS_FOR_INDEX-1:0] curCol;
  logic [BITS_FOR_INDEX-1:0] nextRow;
  logic [BITS_FOR_INDEX-1:0] nextCol;
  logic [COL_AW-1:0]         colAddr;
  logic [3*sizeOfWidth-1:0]  newColumn;
  logic                      emitWindow;

  assign in_ready = out_ready || !out_valid;
  assign accept   = in_valid && in_ready;

  // Position of the pixel on the bus; a qualified start-of-frame overrides the counters
  always_comb begin
    startFrame = in_valid && in_sof;
    curRow     = startFrame ? '0 : rowCnt;
    curCol     = startFrame ? '0 : colCnt;
    colAddr    = curCol[COL_AW-1:0];
    newColumn  = {lineOld[colAddr], lineNew[colAddr], in_pixel};
    // The r>=2 / c>=2 gate is what keeps stale line-buffer data and columns from the
    // previous row or frame out of every emitted window, so no explicit flush is needed
    emitWindow = accept && (curRow >= MIN_POS) && (curCol >= MIN_POS);
    if (curCol == LAST_COL) begin
      nextCol = '0;
      nextRow = (curRow == LAST_ROW) ? '0 : curRow + 1'b1;
    end else begin
      nextCol = curCol + 1'b1;
      nextRow = curRow;
    end
  end

  // Line buffers: the old r-1 entry moves down to r-2 as the new pixel takes its place
  always_ff @(posedge HCLK) begin
    if (accept) begin
      lineOld[colAddr] <= lineNew[colAddr];
      lineNew[colAddr] <= in_pixel;
    end
  end

  // Counters, column shift register and the registered window outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rowCnt    <= '0;
      colCnt    <= '0;
      colPrev1  <= '0;
      colPrev2  <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      temp1     <= '0;
      temp2     <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      if (accept) begin
        rowCnt   <= nextRow;
        colCnt   <= nextCol;
        colPrev2 <= colPrev1;
        colPrev1 <= newColumn;
      end
      if (emitWindow) begin
        out_valid <= 1'b1;
        temp1     <= colPrev2;
        temp2     <= newColumn;
        out_row   <= curRow - 1'b1;
        out_col   <= curCol - 1'b1;
        out_eof   <= (curRow == LAST_ROW) && (curCol == LAST_COL);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 Parameter WIDTH, default 768: image width in pixels.
REQ-002 Parameter HEIGHT, default 512: image height in pixels.
REQ-003 Parameter BITS_FOR_INDEX, default 10: row/column index width, ceil(lg(max(WIDTH,HEIGHT))).
REQ-004 Parameter sizeOfWidth, default 8: bits per grayscale pixel.
REQ-005 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-006 Port HCLK, input, 1: the single clock; all state changes on the rising edge.
REQ-007 Port HRESETn, input, 1: asynchronous active-low reset.
REQ-008 Port in_pixel, input, sizeOfWidth: raster-order grayscale pixel.
REQ-009 Port in_valid, input, 1: in_pixel is valid this cycle.
REQ-010 Port in_sof, input, 1: qualified by in_valid; this pixel is (row 0, col 0).
REQ-011 Port in_ready, output, 1: the block accepts a pixel when in_valid && in_ready.
REQ-012 Port temp1, output, 3*sizeOfWidth: left window column {top,mid,bottom}, top in the MSBs.
REQ-013 Port temp2, output, 3*sizeOfWidth: right window column {top,mid,bottom}, top in the MSBs.
REQ-014 Port out_valid, output, 1: temp1/temp2/out_row/out_col hold a valid window.
REQ-015 Port out_ready, input, 1: downstream Sobel stage consumes the window when out_valid && out_ready.
REQ-016 Port out_row, output, BITS_FOR_INDEX: window centre row.
REQ-017 Port out_col, output, BITS_FOR_INDEX: window centre column.
REQ-018 Port out_eof, output, 1: asserted with the last window of a frame.

Function
REQ-019 The block SHALL hold two line buffers of WIDTH x sizeOfWidth storing rows r-1 and r-2, plus a 3x3 column shift register.
REQ-020 On acceptance of pixel (r,c), the block SHALL read rows r-2 and r-1 at column c, write in_pixel to the row r-1 slot and shift the column {p(r-2,c),p(r-1,c),p(r,c)} into the shift register.
REQ-021 A window SHALL be produced only for accepted pixels with r>=2 and c>=2; temp1 = column c-2, temp2 = column c, out_row = r-1, out_col = c-1.
REQ-022 Latency from the accepting edge to out_valid SHALL be exactly 1 cycle, with outputs registered.
REQ-023 in_ready SHALL equal out_ready || !out_valid, and out_valid/outputs SHALL hold stable while out_valid && !out_ready.
REQ-024 out_valid SHALL drop the cycle after consumption unless a new window is produced on the same edge.
REQ-025 The column counter SHALL wrap from WIDTH-1 to 0 and increment the row; the row SHALL wrap from HEIGHT-1 to 0, which starts the next frame implicitly.
REQ-026 An accepted in_sof SHALL force that pixel to (0,0) regardless of the counter state, and the shift register SHALL be treated as empty.
REQ-027 in_sof without in_valid SHALL be ignored.
REQ-028 out_eof SHALL be 1 only on the window with out_row=HEIGHT-2 and out_col=WIDTH-2.
REQ-029 Each frame SHALL yield exactly (HEIGHT-2)*(WIDTH-2) windows, and no window SHALL span two rows or two frames.

Reset
REQ-030 While HRESETn=0, out_valid, out_eof, temp1, temp2, out_row, out_col, and the counters SHALL be 0; in_ready SHALL be 1 one cycle after release.
REQ-031 Line-buffer contents SHALL be unreset; REQ-021 gating SHALL guarantee that stale data is never emitted.
REQ-032 Reset mid-frame SHALL discard the pending window, and the next accepted pixel SHALL be (0,0).

Verification (WIDTH=4, HEIGHT=4, p(r,c)=4r+c, out_ready=1 unless stated)
REQ-033 Frame sent with in_sof on p(0,0) -> first out_valid one cycle after p(2,2), with temp1=24'h000408, temp2=24'h02060A, out_row=1, out_col=1.
REQ-034 Same frame -> next window temp1=24'h010509, temp2=24'h03070B, out_col=2; exactly 4 windows, out_eof only on (2,2).
REQ-035 out_ready=0 for 3 cycles while a window is pending -> outputs stable, in_ready=0, no pixel lost, window sequence unchanged.
REQ-036 in_sof asserted at p(1,3) of a partial frame -> counters restart, the first window appears after the new p(2,2), and no cross-frame window is produced.
REQ-037 HRESETn pulsed low after p(2,1) -> all outputs 0, then a fresh frame yields REQ-033 values exactly.
REQ-038 Two back-to-back frames with no in_sof on the second -> 8 windows total, and out_eof fires twice.
